// File: rtl/pixbuf_pkg.sv
// rtl/pixbuf_pkg.sv - shared types and constants for the pixel frame buffer
package pixbuf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int TILE_DIM = 8;
  localparam int TILE_SH  = 3;
  localparam int BLK_PIX  = 64;

  function automatic int unsigned pix_depth(input int aw);
    return 32'd1 << aw;
  endfunction

  localparam int          DEF_AW    = 12;
  localparam int unsigned DEF_DEPTH = pix_depth(DEF_AW);

endpackage

// File: rtl/pixel_frame_buf_if.sv
// rtl/pixel_frame_buf_if.sv - write and read pixel stream handshakes
interface pixel_frame_buf_if #(
  parameter int CH = 3,
  parameter int DW = 8
);

  logic              wr_valid;
  logic [CH*DW-1:0]  wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [CH*DW-1:0]  rd_data;
  logic              rd_ready;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/pixbuf_ram.sv
// rtl/pixbuf_ram.sv - simple dual-port pixel memory with synchronous read
module pixbuf_ram
  import pixbuf_pkg::*;
#(
  parameter int W  = 24,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int unsigned DEPTH = pix_depth(AW);

  logic [W-1:0] mem_q [0:DEPTH-1];

  // one write and one registered read per cycle; read data holds while re_i is low
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pixel_frame_buf.sv
// rtl/pixel_frame_buf.sv - frame buffer: raster load, raster or 8x8-tile readout
module pixel_frame_buf
  import pixbuf_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       size_x,
  input  logic [15:0]       size_y,
  input  logic              mode,
  pixel_frame_buf_if.slave  bus,
  output logic              blk_done,
  output logic              frame_done,
  output logic              cfg_err,
  output logic              busy
);

  localparam int          W     = CH * DW;
  localparam int          CW    = AW + 1;
  localparam int unsigned DEPTH = pix_depth(AW);

  state_e         state_q, state_d;
  logic [CW-1:0]  total_q, total_d;
  logic [CW-1:0]  size_x_q, size_x_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]     ix_q, ix_d;
  logic [2:0]     iy_q, iy_d;
  logic [CW-1:0]  tile_col_q, tile_col_d;
  logic [CW-1:0]  row_base_q, row_base_d;
  logic [CW-1:0]  tile_row_base_q, tile_row_base_d;
  logic           pend_q, pend_d;
  logic           rd_valid_q, rd_valid_d;
  logic [W-1:0]   rd_data_q, rd_data_d;
  logic           blk_done_q, blk_done_d;
  logic           frame_done_q, frame_done_d;
  logic           cfg_err_q, cfg_err_d;

  logic [31:0]    total_w;
  logic           reject_w;
  logic           wr_fire, advance, remain, issue, accept;
  logic [AW-1:0]  tile_addr, rd_addr;
  logic [W-1:0]   ram_rdata;

  assign total_w  = 32'(size_x) * 32'(size_y);
  assign reject_w = (total_w == 32'd0) || (total_w > DEPTH) ||
                    (mode && ((size_x[2:0] != 3'd0) || (size_y[2:0] != 3'd0)));

  assign wr_fire   = (state_q == LOAD) && bus.wr_valid;
  assign advance   = !rd_valid_q || bus.rd_ready;
  assign remain    = (iss_cnt_q != total_q);
  assign issue     = (state_q == STREAM) && advance && remain;
  assign accept    = rd_valid_q && bus.rd_ready;
  assign tile_addr = AW'(row_base_q + tile_col_q + CW'(ix_q));
  assign rd_addr   = mode_q ? tile_addr : iss_cnt_q[AW-1:0];

  assign bus.wr_ready = (state_q == LOAD);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign blk_done     = blk_done_q;
  assign frame_done   = frame_done_q;
  assign cfg_err      = cfg_err_q;
  assign busy         = (state_q != IDLE);

  pixbuf_ram #(.W(W), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_cnt_q[AW-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (issue),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // next-state: FSM, write counter, read address generator and two-stage read pipeline
  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    size_x_d        = size_x_q;
    mode_d          = mode_q;
    wr_cnt_d        = wr_cnt_q;
    iss_cnt_d       = iss_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    ix_d            = ix_q;
    iy_d            = iy_q;
    tile_col_d      = tile_col_q;
    row_base_d      = row_base_q;
    tile_row_base_d = tile_row_base_q;
    pend_d          = pend_q;
    rd_valid_d      = rd_valid_q;
    rd_data_d       = rd_data_q;
    blk_done_d      = 1'b0;
    frame_done_d    = 1'b0;
    cfg_err_d       = 1'b0;

    // the RAM output stage and the output register only move together when the
    // output slot is free, so a stalled beat and the one behind it both hold
    if (advance) begin
      rd_valid_d = pend_q;
      if (pend_q) rd_data_d = ram_rdata;
      pend_d = issue;
    end

    // tile walk: column within tile, row within tile, next tile, next tile row
    if (issue) begin
      iss_cnt_d = iss_cnt_q + CW'(1);
      if (ix_q != 3'(TILE_DIM - 1)) begin
        ix_d = ix_q + 3'd1;
      end else begin
        ix_d = 3'd0;
        if (iy_q != 3'(TILE_DIM - 1)) begin
          iy_d       = iy_q + 3'd1;
          row_base_d = row_base_q + size_x_q;
        end else begin
          iy_d = 3'd0;
          if (tile_col_q + CW'(TILE_DIM) != size_x_q) begin
            tile_col_d = tile_col_q + CW'(TILE_DIM);
            row_base_d = tile_row_base_q;
          end else begin
            tile_col_d      = '0;
            tile_row_base_d = tile_row_base_q + (size_x_q << TILE_SH);
            row_base_d      = tile_row_base_q + (size_x_q << TILE_SH);
          end
        end
      end
    end

    if (accept) begin
      rd_cnt_d   = rd_cnt_q + CW'(1);
      blk_done_d = (rd_cnt_q[5:0] == 6'(BLK_PIX - 1));
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (reject_w) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d         = LOAD;
            total_d         = CW'(total_w);
            size_x_d        = CW'(size_x);
            mode_d          = mode;
            wr_cnt_d        = '0;
            iss_cnt_d       = '0;
            rd_cnt_d        = '0;
            ix_d            = '0;
            iy_d            = '0;
            tile_col_d      = '0;
            row_base_d      = '0;
            tile_row_base_d = '0;
          end
        end
      end
      LOAD: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q + CW'(1) == total_q) state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && (rd_cnt_q + CW'(1) == total_q)) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; memory contents are deliberately not reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      total_q         <= '0;
      size_x_q        <= '0;
      mode_q          <= 1'b0;
      wr_cnt_q        <= '0;
      iss_cnt_q       <= '0;
      rd_cnt_q        <= '0;
      ix_q            <= '0;
      iy_q            <= '0;
      tile_col_q      <= '0;
      row_base_q      <= '0;
      tile_row_base_q <= '0;
      pend_q          <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      blk_done_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      size_x_q        <= size_x_d;
      mode_q          <= mode_d;
      wr_cnt_q        <= wr_cnt_d;
      iss_cnt_q       <= iss_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      ix_q            <= ix_d;
      iy_q            <= iy_d;
      tile_col_q      <= tile_col_d;
      row_base_q      <= row_base_d;
      tile_row_base_q <= tile_row_base_d;
      pend_q          <= pend_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
      blk_done_q      <= blk_done_d;
      frame_done_q    <= frame_done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_pixel_frame_buf.sv
// tb/tb_pixel_frame_buf.sv - randomized self-checking bench for pixel_frame_buf
module tb_pixel_frame_buf;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int W  = CH * DW;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [15:0] size_x = '0;
  logic [15:0] size_y = '0;
  logic        blk_done, frame_done, cfg_err, busy;

  pixel_frame_buf_if #(.CH(CH), .DW(DW)) bus ();

  pixel_frame_buf #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .size_x     (size_x),
    .size_y     (size_y),
    .mode       (mode),
    .bus        (bus),
    .blk_done   (blk_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] mdl [0:4095];
  int order_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_order(input int sx, input int sy, input int m);
    order_q.delete();
    if (m == 0) begin
      for (int i = 0; i < sx * sy; i++) order_q.push_back(i);
    end else begin
      for (int ty = 0; ty < sy / 8; ty++)
        for (int tx = 0; tx < sx / 8; tx++)
          for (int iy = 0; iy < 8; iy++)
            for (int ix = 0; ix < 8; ix++)
              order_q.push_back((8 * ty + iy) * sx + 8 * tx + ix);
    end
  endtask

  task automatic fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) mdl[i] = rnd ? W'($urandom) : W'(i);
  endtask

  task automatic do_start(input int sx, input int sy, input int m, input bit ok);
    @(negedge clk);
    size_x = 16'(sx); size_y = 16'(sy); mode = m[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_on_start", {31'd0, cfg_err}, {31'd0, !ok});
    chk("busy_on_start", {31'd0, busy}, {31'd0, ok});
    chk("wr_ready_on_start", {31'd0, bus.wr_ready}, {31'd0, ok});
    if (!ok) begin
      @(negedge clk);
      chk("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
      chk("busy_after_reject", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic load_frame(input int n, input bit poke);
    int idx = 0;
    int cyc = 0;
    int phase = 0;
    bit drove = 1'b0;
    bit rs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (phase == 2) begin
        chk("ignored_start_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        phase = 3;
      end
      if (phase == 1) begin
        start = 1'b0;
        phase = 2;
      end
      if (drove && rs) idx++;
      if (idx == n) break;
      if (cyc > 20000) begin
        chk("load_timeout", cyc, 32'd0);
        break;
      end
      drove = ($urandom_range(0, 3) != 0);
      bus.wr_valid = drove;
      bus.wr_data  = mdl[idx];
      rs = bus.wr_ready;
      if (poke && phase == 0 && idx == n / 2) begin
        start = 1'b1; size_x = 16'd2; size_y = 16'd2; mode = ~mode;
        phase = 1;
      end
    end
    bus.wr_valid = 1'b0;
    start = 1'b0;
    chk("wr_ready_drop", {31'd0, bus.wr_ready}, 32'd0);
  endtask

  task automatic stream_frame(input int sx, input int sy, input int m,
                              input int ready_pct, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int total;
    bit exp_blk = 1'b0;
    bit exp_frm = 1'b0;
    bit pv = 1'b0;
    bit pr = 1'b0;
    bit seen = 1'b0;
    logic [W-1:0] pd = '0;
    total = sx * sy;
    build_order(sx, sy, m);
    forever begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        bus.rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        chk("rst_blk_done", {31'd0, blk_done}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        return;
      end
      chk("blk_done", {31'd0, blk_done}, {31'd0, exp_blk});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_frm});
      if (exp_frm) begin
        chk("rd_valid_fall", {31'd0, bus.rd_valid}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("beat_count", idx, total);
        break;
      end
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("hold_data", 32'(bus.rd_data), 32'(pd));
      end
      if (bus.rd_valid && !seen) begin
        seen = 1'b1;
        chk("first_rd_latency", cyc, 32'd2);
      end
      bus.rd_ready = ($urandom_range(0, 99) < ready_pct);
      exp_blk = 1'b0;
      exp_frm = 1'b0;
      if (bus.rd_valid && bus.rd_ready && idx < total) begin
        chk("rd_data", 32'(bus.rd_data), 32'(mdl[order_q[idx]]));
        idx++;
        exp_blk = (idx % 64 == 0);
        exp_frm = (idx == total);
      end
      pv = bus.rd_valid;
      pr = bus.rd_ready;
      pd = bus.rd_data;
      if (cyc > 30000) begin
        chk("stream_timeout", cyc, 32'd0);
        break;
      end
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic run_frame(input int sx, input int sy, input int m, input bit rnd,
                           input int ready_pct, input bit poke);
    fill(sx * sy, rnd);
    do_start(sx, sy, m, 1'b1);
    load_frame(sx * sy, poke);
    stream_frame(sx, sy, m, ready_pct, -1);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    chk("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset_blk_done", {31'd0, blk_done}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    run_frame(8, 8, 0, 1'b0, 100, 1'b0);
    run_frame(16, 8, 1, 1'b0, 100, 1'b0);
    run_frame(4, 4, 0, 1'b1, 50, 1'b0);
    run_frame(16, 16, 1, 1'b1, 70, 1'b0);
    run_frame(24, 3, 0, 1'b1, 60, 1'b0);

    do_start(10, 8, 1, 1'b0);
    do_start(0, 0, 0, 1'b0);
    do_start(64, 65, 0, 1'b0);
    do_start(8, 12, 1, 1'b0);

    run_frame(64, 64, 1, 1'b1, 90, 1'b0);

    fill(64, 1'b0);
    do_start(8, 8, 0, 1'b1);
    load_frame(64, 1'b0);
    stream_frame(8, 8, 0, 100, 20);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8, 8, 0, 1'b1, 100, 1'b0);

    run_frame(8, 8, 0, 1'b1, 80, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_frame_buf.md
# pixel_frame_buf

Parametrised frame buffer for the compression front end. It accepts one frame of CH-channel pixels in raster order over a valid/ready write port, then streams the frame back out in raster or 8x8-tile order over a valid/ready read port. It flags each 64-pixel block and the end of frame. It sits between the pixel source and the 8x8 transform stage, and replaces file-fed channel memories with a synthesizable, back-pressured buffer.

## Interface
- CH, 3: number of colour channels packed per pixel.
- DW, 8: bits per channel.
- AW, 12: address width; depth is 2^AW pixels.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches size_x, size_y and mode. Honoured only in IDLE.
- size_x  in  16  frame width in pixels.
- size_y  in  16  frame height in pixels.
- mode  in  1  0 = raster read order, 1 = 8x8-tile read order.
- wr_valid  in  1  write beat valid.
- wr_data  in  CH*DW  pixel; channel 0 in the LSBs.
- wr_ready  out  1  high only in LOAD.
- rd_valid  out  1  read beat valid.
- rd_data  out  CH*DW  pixel.
- rd_ready  in  1  downstream accepts a beat.
- blk_done  out  1  one-cycle pulse on every 64th accepted read beat.
- frame_done  out  1  one-cycle pulse on the last accepted read beat.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, LOAD, STREAM.
- IDLE, on start:
  - total = size_x*size_y, computed at 32 bits.
  - Reject if total==0, total>2^AW, or mode==1 with size_x or size_y not a multiple of 8.
  - On reject: pulse cfg_err and stay in IDLE. Otherwise go to LOAD with wr_cnt=0.
- LOAD:
  - Each wr_valid&&wr_ready writes wr_data to address wr_cnt, then wr_cnt increments.
  - The beat that makes wr_cnt==total moves to STREAM. wr_ready drops the next cycle.
- STREAM, address sequence:
  - Raster: 0..total-1.
  - Tile: for each tile row ty, each tile tx, inner row iy, inner column ix, addr = (8*ty+iy)*size_x + 8*tx + ix.
  - Generate addresses incrementally with a row base register and adders; no multiplier in the read path.
- STREAM, beat handling:
  - A beat is accepted when rd_valid&&rd_ready. rd_cnt counts accepted beats.
  - blk_done pulses when rd_cnt[5:0] wraps to 0, in either mode. It never pulses on frames smaller than 64 pixels.
  - On the last accepted beat, pulse frame_done (coincident with blk_done when total%64==0) and return to IDLE.
- start outside IDLE is ignored: no cfg_err and no effect on the operation in progress.
- Memory contents are not cleared by reset or frame end. Only state, counters and outputs are reset.

## Timing
- Reset values: wr_ready=0, rd_valid=0, rd_data=0, blk_done=0, frame_done=0, cfg_err=0, busy=0. State is IDLE and all counters are 0.
- Reset mid-frame aborts immediately with no done pulse.
- start to wr_ready high: 1 cycle.
- Memory read is synchronous, 1 cycle. The first rd_valid occurs 2 cycles after the STREAM entry edge.
- Issue the next read address when (!rd_valid || rd_ready) and read addresses remain. With rd_ready held high, throughput is 1 pixel/cycle.
- While rd_valid && !rd_ready, rd_data and rd_valid are held stable.
- rd_valid falls the cycle after the last accepted beat.
- blk_done, frame_done and cfg_err are registered and assert the cycle after the triggering beat or start.
- LOAD to STREAM: the last write is committed before the first read address is issued, so there is no read-before-write hazard.

## Structure
- Shared package pixbuf_pkg:
  - state enum {IDLE, LOAD, STREAM}.
  - TILE_DIM=8 and BLK_PIX=64 constants.
  - Helper localparam for the 2^AW depth.
- Sub-module pixbuf_ram: simple dual-port RAM, one write and one synchronous read port, width CH*DW, depth 2^AW, no reset.
- The top holds the FSM, counters, tile address generator and output register.

## Test plan
- Raster 8x8 (mode 0): load pixels 0..63 with rd_ready=1. Expect 64 beats in order 0..63, one blk_done and frame_done together on beat 63, then busy=0.
- Tile 16x8 (mode 1): load raster values equal to their address. Expect beats 0..7, 16..23, …, 112..119, then 8..15, 24..31, …; blk_done after beats 63 and 127; frame_done after beat 127.
- Backpressure on a 4x4 raster frame: toggle rd_ready randomly. Expect rd_data stable while stalled, no lost or duplicated pixels, no blk_done, and frame_done after 16 beats.
- Config errors:
  - start with size_x=10, size_y=8, mode=1: cfg_err pulse, busy stays 0.
  - size 0x0: cfg_err.
  - 64x65 with AW=12 (4160 > 4096): cfg_err.
- Reset mid-stream: assert rst_n=0 after beat 20 of a 8x8 frame. All outputs go to reset values asynchronously with no done pulse. A new start then runs a full frame correctly.
- start pulsed during LOAD: ignored. The frame completes normally with the original size.
